// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- instruction decode / register-fetch stage of a five-stage
// pipeline.
//
// Function
//   * Holds the IF/RF pipeline register (pc_rf, ir_rf).
//   * Reads two operands from a 32x32 register file. R31 always reads as
//     zero. Each operand has a bypass path from the ALU, MEM and WB stages.
//   * Detects load-use hazards and inserts a one-cycle bubble.
//   * Drives the branch and jump controls back to fetch.
//   * Produces the registered RF/ALU pipeline outputs.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   pc_in, ir_in               PC+4 and instruction from fetch
//   alu_wr/alu_is_ld/alu_rc    ALU-stage writeback valid, load flag,
//                              destination register
//   alu_data                   ALU-stage bypass data
//   mem_wr/mem_rc/mem_data     MEM-stage writeback valid, destination, data
//   wb_wr/wb_rc/wb_data        WB-stage register-file write port
//   stall, zr, ill_op,
//   op_jmp, op_beq, op_bne     combinational controls to fetch
//   br_addr, j_addr            branch and jump targets to fetch
//   pc_out, ir_out,
//   a_out, b_out, d_out        registered RF/ALU pipeline outputs
// ---------------------------------------------------------------------------
module decode #(
    parameter logic [31:0] PC_RESET_ADDR   = 32'h0000_0000,
    // Default NOP encoding: ADD(R31,R31,R31)
    parameter logic [31:0] INST_NOP        = 32'h83FF_F800,
    // Default exception encoding: BNE(R31,0,R30), which traps via XP
    parameter logic [31:0] INST_BNE_EXCEPT = 32'h7BDF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] ir_in,
    input  logic        alu_wr,
    input  logic        alu_is_ld,
    input  logic [4:0]  alu_rc,
    input  logic [31:0] alu_data,
    input  logic        mem_wr,
    input  logic [4:0]  mem_rc,
    input  logic [31:0] mem_data,
    input  logic        wb_wr,
    input  logic [4:0]  wb_rc,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        zr,
    output logic        ill_op,
    output logic        op_jmp,
    output logic        op_beq,
    output logic        op_bne,
    output logic [31:0] br_addr,
    output logic [31:0] j_addr,
    output logic [31:0] pc_out,
    output logic [31:0] ir_out,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] d_out
);

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1D;
    localparam logic [5:0] OP_BNE = 6'h1E;
    localparam logic [5:0] OP_LDR = 6'h1F;
    localparam logic [4:0] R_ZERO = 5'd31;

    // IF/RF pipeline register
    logic [31:0] pc_rf;
    logic [31:0] ir_rf;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] lit;
    logic [31:0] sxt;

    assign opcode = ir_rf[31:26];
    assign rc     = ir_rf[25:21];
    assign ra     = ir_rf[20:16];
    assign rb     = ir_rf[15:11];
    assign lit    = ir_rf[15:0];
    assign sxt    = {{16{lit[15]}}, lit};

    // Register file. Contents are not reset, and writes to R31 are dropped.
    // The read is combinational because both the bypass network and the
    // branch decision need the operand in the same cycle.
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (wb_wr && wb_rc != R_ZERO) begin
            regs[wb_rc] <= wb_data;
        end
    end

    // Two operand ports. Port 0 reads ra. Port 1 reads rc for ST, because
    // ST needs the store data register, and rb for every other instruction.
    // Bypass priority is youngest producer first: ALU, then MEM, then WB.
    // The WB bypass also covers a write and a read of the same register in
    // one cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [4:0]  sel;
        logic [31:0] val;

        if (gi == 0) begin : g_a
            assign sel = ra;
        end else begin : g_b
            assign sel = (opcode == OP_ST) ? rc : rb;
        end

        always_comb begin
            val = 32'd0;
            if (sel == R_ZERO) begin
                val = 32'd0;
            end else if (alu_wr && alu_rc == sel) begin
                val = alu_data;
            end else if (mem_wr && mem_rc == sel) begin
                val = mem_data;
            end else if (wb_wr && wb_rc == sel) begin
                val = wb_data;
            end else begin
                val = regs[sel];
            end
        end
    end

    logic [31:0] port_a;
    logic [31:0] port_b;
    assign port_a = g_port[0].val;
    assign port_b = g_port[1].val;

    // Opcode classification.
    // Every operate-class opcode (0x20-0x3F) is legal except those whose
    // low three bits are all ones.
    logic legal;
    logic reads_a;
    logic reads_b;
    logic uses_lit;

    assign legal = (opcode[5] && opcode[2:0] != 3'b111) ||
                   opcode == OP_LD  || opcode == OP_ST  ||
                   opcode == OP_JMP || opcode == OP_BEQ ||
                   opcode == OP_BNE || opcode == OP_LDR;

    // LDR addresses relative to the PC, so it is the only instruction that
    // does not read ra.
    assign reads_a  = (opcode != OP_LDR);
    assign reads_b  = (opcode >= 6'h20 && opcode <= 6'h2E) || opcode == OP_ST;
    assign uses_lit = (opcode[5:4] == 2'b11) || opcode == OP_LD ||
                      opcode == OP_ST || opcode == OP_LDR;

    // Load-use hazard. The load result is not available until MEM, so the
    // consumer waits in IF/RF for one cycle and then takes the MEM bypass.
    assign stall = alu_is_ld && alu_wr && (alu_rc != R_ZERO) &&
                   ((reads_a && alu_rc == ra) ||
                    (reads_b && alu_rc == g_port[1].sel));

    // Fetch controls
    assign op_jmp  = !stall && (opcode == OP_JMP);
    assign op_beq  = !stall && (opcode == OP_BEQ);
    assign op_bne  = !stall && (opcode == OP_BNE);
    assign ill_op  = !stall && !legal;
    assign zr      = (port_a == 32'd0);
    assign br_addr = pc_rf + {sxt[29:0], 2'b00};
    assign j_addr  = {port_a[31:2], 2'b00};

    // Second ALU operand: the literal for immediate, load and store forms,
    // a word offset for LDR, and the register otherwise.
    logic [31:0] b_sel;
    always_comb begin
        b_sel = port_b;
        if (opcode == OP_LDR) begin
            b_sel = {sxt[29:0], 2'b00};
        end else if (uses_lit) begin
            b_sel = sxt;
        end
    end

    // IF/RF and RF/ALU pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_rf  <= PC_RESET_ADDR;
            ir_rf  <= INST_NOP;
            pc_out <= PC_RESET_ADDR;
            ir_out <= INST_NOP;
            a_out  <= 32'd0;
            b_out  <= 32'd0;
            d_out  <= 32'd0;
        end else begin
            if (!stall) begin
                pc_rf <= pc_in;
                ir_rf <= ir_in;
            end
            pc_out <= pc_rf;
            if (stall) begin
                // Bubble. The stalled instruction stays in IF/RF.
                ir_out <= INST_NOP;
                a_out  <= 32'd0;
                b_out  <= 32'd0;
                d_out  <= 32'd0;
            end else if (!legal) begin
                // Illegal instruction: replace it with the exception branch.
                ir_out <= INST_BNE_EXCEPT;
                a_out  <= 32'd0;
                b_out  <= 32'd0;
                d_out  <= 32'd0;
            end else begin
                ir_out <= ir_rf;
                a_out  <= (opcode == OP_LDR) ? pc_rf : port_a;
                b_out  <= b_sel;
                d_out  <= port_b;
            end
        end
    end

endmodule
